serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Serial frame receiver that sits directly downstream of the team's shift-register stage. It consumes the MSB-first serial bit stream that stage emits on `sout`. It delineates frames (start bit, N data bits, optional even parity, stop bit), reassembles the data word, and presents it on a one-entry valid/ready output register. It flags parity errors, framing errors and overruns so the consuming pipeline can drop bad words.

## Interface
Parameters:
- `N`, default 8 (equals `SHIFT_LEN`): data bits per frame; legal range 2..32.
- `PARITY_EN`, default 1: 1 = even parity bit follows the data bits; 0 = no parity bit.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bit_en`  in  1  bit strobe; `sin` is sampled only on edges where `bit_en`=1.
- `sin`  in  1  serial line; idles at 1.
- `data_out`  out  N  received word, first-received bit in bit N-1.
- `out_valid`  out  1  `data_out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word when `out_valid` && `out_ready`.
- `parity_err`  out  1  1-cycle pulse: frame dropped on parity mismatch.
- `frame_err`  out  1  1-cycle pulse: frame dropped because the stop bit was 0.
- `overrun`  out  1  1-cycle pulse: good frame dropped because the output slot was occupied.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states and transitions, all taken on strobed edges (`bit_en`=1):
  - IDLE: `sin`=0 → DATA, with the bit counter cleared.
  - DATA: shift `sin` into an internal register LSB-in (`sh <= {sh[N-2:0], sin}`). After the N-th bit, go to PARITY if `PARITY_EN`, else to STOP.
  - PARITY: latch `sin` as the parity bit → STOP.
  - STOP: evaluate the frame and return to IDLE.
- Edges with `bit_en`=0 hold all state; pulse outputs are 0 on those edges.
- The bit counter is `$clog2(N+1)` bits wide. It counts 0..N-1 and never wraps past N-1.
- Even parity rule: XOR of the N data bits XOR the parity bit must equal 0.
- STOP evaluation, in priority order:
  1. `sin`=0 → `frame_err` pulse; word discarded.
  2. Parity mismatch → `parity_err` pulse; word discarded.
  3. Output slot is free, or is being consumed on this same edge → `data_out` <= word and `out_valid` <= 1.
  4. Otherwise → `overrun` pulse; new word discarded; the old word is retained.
- `out_valid` clears on an edge where `out_valid` && `out_ready`, unless step 3 reloads it on that same edge.
- `data_out` changes only on a load and holds otherwise.
- Reset values: `data_out`=0, `out_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, counter=0, shift register=0.
- Reset asserted mid-frame: the partial frame is lost and any held word is discarded. A line low level present at reset release counts as a start bit only on the first strobed edge after release.

## Timing
- Frame length F = N + 2 + `PARITY_EN` strobed bits.
- `out_valid`, `data_out` and the error pulses all update on the edge that samples the stop bit. They are visible in the cycle after that edge.
- With `bit_en` tied to 1, a start bit sampled on edge k puts the word on the outputs after edge k+F-1.
- Back-to-back frames are supported. IDLE accepts a start bit on the strobed edge immediately after STOP, with no idle bit required.
- `out_ready` has no combinational path to any output. All outputs are registered.
- Error pulses are exactly 1 `clk` cycle wide, regardless of `bit_en`.

## Test plan
- Reset behaviour: assert `reset` for 2 cycles while in mid-DATA, then idle the line → all outputs 0, `busy`=0; a subsequent good frame 0xA5 is received correctly.
- Good frame: N=8, `PARITY_EN`=1, `bit_en`=1, line 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5, parity 0, stop) → `data_out`=0xA5 and `out_valid`=1 exactly 11 cycles after the start edge; no error pulses.
- Parity error: same frame with parity bit 1 → one `parity_err` pulse; `out_valid` stays 0.
- Framing error: 0x3C with correct parity but stop bit 0 → one `frame_err` pulse; no load.
- Overrun and simultaneous consume:
  - Two back-to-back frames 0x11, 0x22 with `out_ready`=0 → `overrun` pulses once and `data_out` stays 0x11.
  - Repeat with `out_ready`=1 on the 0x22 stop edge → `data_out`=0x22, `out_valid` stays 1, no overrun.
- Strobed operation: `bit_en` high every 4th cycle, frame 0xFF (parity 0) → received 0xFF; state holds on non-strobed cycles, checked via `busy` staying 1 across the 44-cycle frame.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, N data bits MSB-first, optional even parity, stop bit.
// Delivers each good word into a one-entry valid/ready output slot and pulses error flags.
module serial_frame_rx #(
   parameter int N         = 8,
   parameter int PARITY_EN = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         bit_en,
   input  logic         sin,
   output logic [N-1:0] data_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         parity_err,
   output logic         frame_err,
   output logic         overrun,
   output logic         busy
);

   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  sh_q, sh_d;
   logic          par_q, par_d;
   logic [N-1:0]  data_q, data_d;
   logic          valid_q, valid_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      par_d   = par_q;
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      if (bit_en) begin
         case (state_q)
            S_IDLE: begin
               if (!sin) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               sh_d = {sh_q[N-2:0], sin};
               if (cnt_q == CW'(N - 1)) begin
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_PARITY: begin
               par_d   = sin;
               state_d = S_STOP;
            end
            default: begin
               // Stop bit: framing beats parity beats overrun; a same-edge consume frees the slot.
               state_d = S_IDLE;
               if (!sin) begin
                  ferr_d = 1'b1;
               end else if ((PARITY_EN != 0) && ((^sh_q) ^ par_q)) begin
                  perr_d = 1'b1;
               end else if (!valid_q || out_ready) begin
                  data_d  = sh_q;
                  valid_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   assign data_out   = data_q;
   assign out_valid  = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (N=8, even parity): frame table plus reset,
// latency and bit-strobed sequences.
module tb_serial_frame_rx;

   logic       clk;
   logic       reset;
   logic       bit_en;
   logic       sin;
   logic [7:0] data_out;
   logic       out_valid;
   logic       out_ready;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests_run = 0;
   int tests_failed = 0;

   serial_frame_rx #(.N(8), .PARITY_EN(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .bit_en     (bit_en),
      .sin        (sin),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic       rdy;
      logic       drain;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic rdy);
      sin       = b;
      bit_en    = 1'b1;
      out_ready = rdy;
      tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic rdy);
      send_bit(1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
      send_bit(p, 1'b0);
      send_bit(s, rdy);
      bit_en    = 1'b0;
      sin       = 1'b1;
      out_ready = 1'b0;
   endtask

   task automatic drain();
      bit_en    = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("drain_valid", out_valid, 0);
      check("drain_pulses", {parity_err, frame_err, overrun}, 0);
   endtask

   // One strobed bit followed by three unstrobed cycles during which the FSM must hold.
   task automatic strobed_bit(input logic b);
      sin    = b;
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         check("strobe_busy_hold", busy, 1);
      end
   endtask

   task automatic strobed_frame_body(input logic [7:0] d, input logic p);
      strobed_bit(1'b0);
      for (int i = 7; i >= 0; i--) strobed_bit(d[i]);
      strobed_bit(p);
      sin    = 1'b1;
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
   endtask

   logic [7:0] a5;

   initial begin
      //           data   par   stop  rdy   drain valid edata perr  ferr  ovr
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};

      reset     = 1'b1;
      bit_en    = 1'b0;
      sin       = 1'b1;
      out_ready = 1'b0;
      tick();
      tick();
      tick();
      check("rst_data", data_out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_perr", parity_err, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      tick();

      for (int v = 0; v < 10; v++) begin
         send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, vecs[v].rdy);
         check("tbl_valid", out_valid, vecs[v].exp_valid);
         check("tbl_data", data_out, vecs[v].exp_data);
         check("tbl_perr", parity_err, vecs[v].exp_perr);
         check("tbl_ferr", frame_err, vecs[v].exp_ferr);
         check("tbl_ovr", overrun, vecs[v].exp_ovr);
         check("tbl_busy", busy, 0);
         if (vecs[v].drain) drain();
      end

      // Reset mid-DATA with a word still held in the slot.
      check("pre_rst_valid", out_valid, 1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      check("mid_busy", busy, 1);
      reset = 1'b1;
      sin   = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      check("mrst_data", data_out, 0);
      check("mrst_valid", out_valid, 0);
      check("mrst_pulses", {parity_err, frame_err, overrun}, 0);
      check("mrst_busy", busy, 0);

      // Latency: word appears only after the 11th edge (stop), not after the 10th.
      a5 = 8'hA5;
      send_bit(1'b0, 1'b0);
      check("lat_busy_start", busy, 1);
      for (int i = 7; i >= 0; i--) send_bit(a5[i], 1'b0);
      send_bit(1'b0, 1'b0);
      check("lat_valid_e10", out_valid, 0);
      check("lat_busy_e10", busy, 1);
      send_bit(1'b1, 1'b0);
      bit_en = 1'b0;
      check("lat_valid_e11", out_valid, 1);
      check("lat_data_e11", data_out, 8'hA5);
      check("lat_pulses", {parity_err, frame_err, overrun}, 0);
      check("lat_busy_end", busy, 0);
      drain();

      // Strobed every 4th cycle: good 0xFF.
      strobed_frame_body(8'hFF, 1'b0);
      check("strb_data", data_out, 8'hFF);
      check("strb_valid", out_valid, 1);
      check("strb_busy_end", busy, 0);
      check("strb_pulses", {parity_err, frame_err, overrun}, 0);
      drain();

      // Strobed parity error: pulse lasts exactly one clk despite slow strobe.
      strobed_frame_body(8'h0F, 1'b1);
      check("strb_perr_on", parity_err, 1);
      check("strb_perr_valid", out_valid, 0);
      tick();
      check("strb_perr_off", parity_err, 0);
      check("strb_perr_data", data_out, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
